fetch_responder: RTL and testbench
==================================

Name: fetch_responder

Overview:
- Memory-side responder to the fetch-decode-execute sequencer (`fdemachine`).
- Each time the sequencer enters FETCH, the block runs one request/acknowledge read on the instruction memory port, loads the instruction register and advances the program counter.
- Owns PC and IR for the 16-bit core. Reports completion or timeout back to control.

Parameters:
- ADDR_W, 16, width of PC and memory address.
- DATA_W, 16, instruction / memory data width.
- RESET_PC, 16'h0000, PC value after reset.
- TIMEOUT, 8, max cycles in REQ without mem_ack before error (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  enable; same signal that drives the sequencer.
- state  in  2  sequencer state (FETCH/DECODE/EXECUTE/HALT encoding).
- pc_load  in  1  load PC from pc_target; honoured only while state==EXECUTE.
- pc_target  in  ADDR_W  branch/jump target.
- mem_req  out  1  read request to instruction memory.
- mem_addr  out  ADDR_W  read address, valid while mem_req=1.
- mem_ack  in  1  memory acknowledge; mem_rdata valid the same cycle.
- mem_rdata  in  DATA_W  read data.
- ir  out  DATA_W  instruction register.
- pc  out  ADDR_W  program counter.
- fetch_done  out  1  one-cycle pulse when IR is loaded.
- fetch_err  out  1  sticky timeout flag.

Behaviour:
- Interface: one clock clk; reset rst is asynchronous and active-high.
- Reset values: mem_req=0, mem_addr=0, ir=0, pc=RESET_PC, fetch_done=0, fetch_err=0, internal FSM=IDLE, prev_state=HALT (2'b11), timeout counter=0.
- Trigger: start = en & (state==FETCH) & (prev_state!=FETCH). prev_state registers state every cycle. A FETCH on the first cycle after reset therefore triggers.
- FSM states: IDLE, REQ, ERR.
- IDLE: mem_req=0. On start: go to REQ, mem_req<=1, mem_addr<=pc, counter<=0.
- REQ: mem_req and mem_addr stay stable until mem_ack. Requests are never withdrawn without an ack.
  - On mem_ack: ir<=mem_rdata, pc<=pc+1 (mod 2^ADDR_W, so FFFF wraps to 0000), fetch_done<=1 for the next cycle only, mem_req<=0, return to IDLE.
  - Without mem_ack: counter++. When counter reaches TIMEOUT-1 without ack: mem_req<=0, fetch_err<=1, go to ERR; ir and pc unchanged.
- Latency: a zero-wait memory acks in the first REQ cycle. State goes FETCH at cycle N, mem_req=1 at N+1, ir/pc/fetch_done updated at N+2.
- ERR: terminal; mem_req=0, fetch_err=1, ignores start and pc_load. Only rst exits.
- en low: no new fetch starts. An in-flight REQ still completes or times out.
- state leaves FETCH during REQ: request still completes. IR/PC update as normal; fetch_done still pulses.
- pc_load: pc<=pc_target when pc_load & (state==EXECUTE) & FSM!=ERR. Otherwise ignored. It cannot collide with the ack increment, because the trigger rules keep REQ out of EXECUTE under a compliant sequencer. If both occur in the same cycle anyway, pc_load wins.
- mem_ack while in IDLE or ERR: ignored, no state change.
- Reset mid-REQ: outputs return to reset values immediately (async); no ack is consumed afterward.

Decomposition:
- Shared package/include (the state definitions file used by the sequencer): state encodings FETCH=2'b00, DECODE=2'b01, EXECUTE=2'b10, HALT=2'b11.
- Same file: responder FSM codes IDLE=2'b00, REQ=2'b01, ERR=2'b10.
- One natural sub-module: fetch_timeout_counter (clear, increment, terminal-count flag at TIMEOUT-1). The rest stays in one module.

Test Plan:
- Zero-wait fetch: reset, RESET_PC=0, state=FETCH at cycle 2, memory acks immediately with 16'hA5C3 -> mem_req high one cycle at addr 0, ir=16'hA5C3, pc=1, fetch_done single pulse.
- Wait states: ack 3 cycles after req with 16'h1234 -> mem_req/mem_addr stable for 4 cycles, then ir=16'h1234, pc incremented once.
- Wrap and branch: pc_load in EXECUTE with target 16'hFFFF, then FETCH, ack 16'h0F0F -> mem_addr=16'hFFFF, pc=16'h0000 after ack. Also pc_load during DECODE -> pc unchanged.
- Timeout: TIMEOUT=8, no ack -> mem_req drops after 8 cycles, fetch_err=1 and stays 1. A later FETCH issues no request; ir/pc unchanged.
- en/state interplay: en=0 with state=FETCH -> no request. state held at FETCH across 5 cycles -> exactly one request. State moves to DECODE mid-REQ -> ack still loads ir and pulses fetch_done.
- Async reset: assert rst mid-REQ between clock edges -> mem_req=0, pc=RESET_PC, ir=0 immediately. After release, FETCH triggers a new fetch at RESET_PC.

Source files
------------

// File: rtl/fetch_responder_pkg.sv
// rtl/fetch_responder_pkg.sv - shared sequencer state codes and responder FSM codes
//
// Purpose: state encodings shared with the fdemachine sequencer, the responder's
//          own FSM encoding, and a width helper for the timeout counter.
// Ports:   none (package).

package fetch_responder_pkg;

    // Sequencer states, as driven on fetch_responder.state.
    typedef enum logic [1:0] {
        FETCH   = 2'b00,
        DECODE  = 2'b01,
        EXECUTE = 2'b10,
        HALT    = 2'b11
    } seq_state_t;

    // Responder FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        ERR  = 2'b10
    } resp_state_t;

    // Counter width able to hold 0..limit-1; never narrower than one bit.
    function automatic int cnt_width(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// rtl/fetch_timeout_counter.sv - wait-cycle counter for an outstanding fetch request
//
// Purpose: counts REQ cycles without acknowledge; tc flags the last allowed
//          cycle (count == TIMEOUT-1).
// Ports:
//   clk   in  system clock, rising edge
//   rst   in  asynchronous active-high reset
//   clear in  restart the count at zero (new request issued)
//   inc   in  one more cycle waited without acknowledge
//   tc    out count has reached TIMEOUT-1

module fetch_timeout_counter
    import fetch_responder_pkg::*;
#(
    parameter int TIMEOUT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic tc
);

    localparam int            CW   = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    // Saturates at LAST so the counter can never wrap back below the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != LAST)) begin
            count <= count + CW'(1);
        end
    end

    assign tc = (count == LAST);

endmodule

// File: rtl/fetch_responder.sv
// rtl/fetch_responder.sv - instruction fetch responder owning PC and IR
//
// Purpose: on each entry of the sequencer into FETCH, performs one req/ack read
//          of instruction memory at PC, loads IR, advances PC; reports a one-cycle
//          fetch_done or a sticky fetch_err on timeout.
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   en                  enable shared with the sequencer
//   state               sequencer state (FETCH/DECODE/EXECUTE/HALT)
//   pc_load, pc_target  branch/jump load, honoured only in EXECUTE
//   mem_req, mem_addr   read request and address to instruction memory
//   mem_ack, mem_rdata  acknowledge with same-cycle read data
//   ir, pc              instruction register, program counter
//   fetch_done          one-cycle pulse when IR is loaded
//   fetch_err           sticky timeout flag

module fetch_responder
    import fetch_responder_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                TIMEOUT  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        state,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_target,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] pc,
    output logic              fetch_done,
    output logic              fetch_err
);

    resp_state_t       fsm, fsm_nxt;
    seq_state_t        prev_state;
    logic              start;
    logic              cnt_clear, cnt_inc, cnt_tc;
    logic              mem_req_nxt, fetch_done_nxt, fetch_err_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt, pc_nxt;
    logic [DATA_W-1:0] ir_nxt;

    // Only the first cycle of a FETCH visit starts a read; prev_state resets to
    // HALT so a FETCH right after reset counts as an entry.
    assign start = en && (state == FETCH) && (prev_state != FETCH);

    fetch_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .tc    (cnt_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm <= IDLE;
        end else begin
            fsm <= fsm_nxt;
        end
    end

    always_comb begin
        fsm_nxt        = fsm;
        mem_req_nxt    = mem_req;
        mem_addr_nxt   = mem_addr;
        ir_nxt         = ir;
        pc_nxt         = pc;
        fetch_done_nxt = 1'b0;
        fetch_err_nxt  = fetch_err;
        cnt_clear      = 1'b0;
        cnt_inc        = 1'b0;

        case (fsm)
            IDLE: begin
                mem_req_nxt = 1'b0;
                if (start) begin
                    fsm_nxt      = REQ;
                    mem_req_nxt  = 1'b1;
                    mem_addr_nxt = pc;
                    cnt_clear    = 1'b1;
                end
            end
            REQ: begin
                // Ack takes priority over timeout on the last allowed cycle.
                if (mem_ack) begin
                    fsm_nxt        = IDLE;
                    mem_req_nxt    = 1'b0;
                    ir_nxt         = mem_rdata;
                    pc_nxt         = pc + ADDR_W'(1);
                    fetch_done_nxt = 1'b1;
                end else if (cnt_tc) begin
                    fsm_nxt       = ERR;
                    mem_req_nxt   = 1'b0;
                    fetch_err_nxt = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ERR: begin
                mem_req_nxt   = 1'b0;
                fetch_err_nxt = 1'b1;
            end
            default: begin
                fsm_nxt     = IDLE;
                mem_req_nxt = 1'b0;
            end
        endcase

        // Placed after the FSM so a branch load overrides the ack increment.
        if (pc_load && (state == EXECUTE) && (fsm != ERR)) begin
            pc_nxt = pc_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_state <= HALT;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            ir         <= '0;
            pc         <= RESET_PC;
            fetch_done <= 1'b0;
            fetch_err  <= 1'b0;
        end else begin
            prev_state <= seq_state_t'(state);
            mem_req    <= mem_req_nxt;
            mem_addr   <= mem_addr_nxt;
            ir         <= ir_nxt;
            pc         <= pc_nxt;
            fetch_done <= fetch_done_nxt;
            fetch_err  <= fetch_err_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_responder.sv
// tb/tb_fetch_responder.sv - self-checking bench for fetch_responder

module tb_fetch_responder;

    localparam int         TIMEOUT = 8;
    localparam logic [1:0] S_F = 2'b00, S_D = 2'b01, S_E = 2'b10, S_H = 2'b11;

    logic        clk = 1'b0;
    logic        rst, en, pc_load, mem_ack;
    logic [1:0]  state;
    logic [15:0] pc_target, mem_rdata;
    logic        mem_req, fetch_done, fetch_err;
    logic [15:0] mem_addr, ir, pc;

    int errors = 0;
    int checks = 0;

    fetch_responder #(
        .ADDR_W   (16),
        .DATA_W   (16),
        .RESET_PC (16'h0000),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .state      (state),
        .pc_load    (pc_load),
        .pc_target  (pc_target),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .ir         (ir),
        .pc         (pc),
        .fetch_done (fetch_done),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    // Reference model: a fetch is "outstanding" for some number of cycles;
    // it ends with an ack or after TIMEOUT unacknowledged cycles.
    logic        m_req, m_done, m_err;
    logic [15:0] m_addr, m_ir, m_pc;
    logic [1:0]  m_prev;
    int          m_waited;

    task automatic model_reset();
        m_req = 0; m_done = 0; m_err = 0;
        m_addr = 0; m_ir = 0; m_pc = 16'h0000;
        m_prev = S_H; m_waited = 0;
    endtask

    task automatic model_edge();
        logic        entered, was_err;
        logic [15:0] old_pc;
        entered = en && (state == S_F) && (m_prev != S_F);
        was_err = m_err;
        old_pc  = m_pc;
        m_done  = 0;
        if (was_err) begin
            m_req = 0;
        end else if (m_req) begin
            if (mem_ack) begin
                m_ir = mem_rdata; m_pc = old_pc + 16'd1; m_done = 1; m_req = 0;
            end else begin
                m_waited++;
                if (m_waited == TIMEOUT) begin
                    m_req = 0; m_err = 1;
                end
            end
        end else if (entered) begin
            m_req = 1; m_addr = old_pc; m_waited = 0;
        end
        if (pc_load && state == S_E && !was_err) m_pc = pc_target;
        m_prev = state;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!rst) model_edge();
        #1;
    endtask

    task automatic drive(input logic e, input logic [1:0] s, input logic ld,
                         input logic [15:0] tgt, input logic ack, input logic [15:0] rd);
        en = e; state = s; pc_load = ld; pc_target = tgt; mem_ack = ack; mem_rdata = rd;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic expect_all(input string nm, input logic req, input logic [15:0] addr,
                              input logic [15:0] ir_e, input logic [15:0] pc_e,
                              input logic done, input logic err);
        chk($sformatf("%s.mem_req", nm), 32'(mem_req), 32'(req));
        chk($sformatf("%s.mem_addr", nm), 32'(mem_addr), 32'(addr));
        chk($sformatf("%s.ir", nm), 32'(ir), 32'(ir_e));
        chk($sformatf("%s.pc", nm), 32'(pc), 32'(pc_e));
        chk($sformatf("%s.fetch_done", nm), 32'(fetch_done), 32'(done));
        chk($sformatf("%s.fetch_err", nm), 32'(fetch_err), 32'(err));
    endtask

    task automatic check_model(input string nm);
        expect_all(nm, m_req, m_addr, m_ir, m_pc, m_done, m_err);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b1, S_H, 1'b0, 16'h0, 1'b0, 16'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic        en;
        logic [1:0]  st;
        logic        ld;
        logic [15:0] tgt;
        logic        ack;
        logic [15:0] rd;
        logic        req;
        logic [15:0] addr;
        logic [15:0] ir;
        logic [15:0] pc;
        logic        done;
        logic        err;
    } vec_t;

    function automatic vec_t v(input logic e, input logic [1:0] s, input logic ld,
                               input logic [15:0] tgt, input logic ack, input logic [15:0] rd,
                               input logic req, input logic [15:0] addr, input logic [15:0] ir_e,
                               input logic [15:0] pc_e, input logic done, input logic err);
        vec_t r;
        r.en = e; r.st = s; r.ld = ld; r.tgt = tgt; r.ack = ack; r.rd = rd;
        r.req = req; r.addr = addr; r.ir = ir_e; r.pc = pc_e; r.done = done; r.err = err;
        return r;
    endfunction

    vec_t tbl[$];

    initial begin
        // Zero-wait fetch
        tbl.push_back(v(1, S_H, 0, 16'h0,    0, 16'h0,    0, 16'h0000, 16'h0000, 16'h0000, 0, 0));
        tbl.push_back(v(1, S_F, 0, 16'h0,    0, 16'h0,    1, 16'h0000, 16'h0000, 16'h0000, 0, 0));
        tbl.push_back(v(1, S_F, 0, 16'h0,    1, 16'hA5C3, 0, 16'h0000, 16'hA5C3, 16'h0001, 1, 0));
        tbl.push_back(v(1, S_D, 0, 16'h0,    0, 16'h0,    0, 16'h0000, 16'hA5C3, 16'h0001, 0, 0));
        tbl.push_back(v(1, S_E, 0, 16'h0,    0, 16'h0,    0, 16'h0000, 16'hA5C3, 16'h0001, 0, 0));
        // Wait states: ack on the fourth request cycle
        tbl.push_back(v(1, S_F, 0, 16'h0,    0, 16'h0,    1, 16'h0001, 16'hA5C3, 16'h0001, 0, 0));
        tbl.push_back(v(1, S_F, 0, 16'h0,    0, 16'h0,    1, 16'h0001, 16'hA5C3, 16'h0001, 0, 0));
        tbl.push_back(v(1, S_F, 0, 16'h0,    0, 16'h0,    1, 16'h0001, 16'hA5C3, 16'h0001, 0, 0));
        tbl.push_back(v(1, S_F, 0, 16'h0,    0, 16'h0,    1, 16'h0001, 16'hA5C3, 16'h0001, 0, 0));
        tbl.push_back(v(1, S_F, 0, 16'h0,    1, 16'h1234, 0, 16'h0001, 16'h1234, 16'h0002, 1, 0));
        // Branch ignored in DECODE, taken in EXECUTE, then wrap
        tbl.push_back(v(1, S_D, 1, 16'h5555, 0, 16'h0,    0, 16'h0001, 16'h1234, 16'h0002, 0, 0));
        tbl.push_back(v(1, S_E, 1, 16'hFFFF, 0, 16'h0,    0, 16'h0001, 16'h1234, 16'hFFFF, 0, 0));
        tbl.push_back(v(1, S_F, 0, 16'h0,    0, 16'h0,    1, 16'hFFFF, 16'h1234, 16'hFFFF, 0, 0));
        tbl.push_back(v(1, S_F, 0, 16'h0,    1, 16'h0F0F, 0, 16'hFFFF, 16'h0F0F, 16'h0000, 1, 0));
        tbl.push_back(v(1, S_D, 0, 16'h0,    0, 16'h0,    0, 16'hFFFF, 16'h0F0F, 16'h0000, 0, 0));
        // en low blocks a FETCH entry; a held FETCH is not a new entry
        tbl.push_back(v(0, S_H, 0, 16'h0,    0, 16'h0,    0, 16'hFFFF, 16'h0F0F, 16'h0000, 0, 0));
        tbl.push_back(v(0, S_F, 0, 16'h0,    0, 16'h0,    0, 16'hFFFF, 16'h0F0F, 16'h0000, 0, 0));
        tbl.push_back(v(1, S_F, 0, 16'h0,    0, 16'h0,    0, 16'hFFFF, 16'h0F0F, 16'h0000, 0, 0));
        tbl.push_back(v(1, S_H, 0, 16'h0,    0, 16'h0,    0, 16'hFFFF, 16'h0F0F, 16'h0000, 0, 0));
        // FETCH held five cycles: exactly one request
        tbl.push_back(v(1, S_F, 0, 16'h0,    0, 16'h0,    1, 16'h0000, 16'h0F0F, 16'h0000, 0, 0));
        tbl.push_back(v(1, S_F, 0, 16'h0,    1, 16'h7777, 0, 16'h0000, 16'h7777, 16'h0001, 1, 0));
        tbl.push_back(v(1, S_F, 0, 16'h0,    0, 16'h0,    0, 16'h0000, 16'h7777, 16'h0001, 0, 0));
        tbl.push_back(v(1, S_F, 0, 16'h0,    0, 16'h0,    0, 16'h0000, 16'h7777, 16'h0001, 0, 0));
        tbl.push_back(v(1, S_F, 0, 16'h0,    0, 16'h0,    0, 16'h0000, 16'h7777, 16'h0001, 0, 0));
        // State leaves FETCH mid-request; then a stray ack in IDLE
        tbl.push_back(v(1, S_D, 0, 16'h0,    0, 16'h0,    0, 16'h0000, 16'h7777, 16'h0001, 0, 0));
        tbl.push_back(v(1, S_F, 0, 16'h0,    0, 16'h0,    1, 16'h0001, 16'h7777, 16'h0001, 0, 0));
        tbl.push_back(v(1, S_D, 0, 16'h0,    0, 16'h0,    1, 16'h0001, 16'h7777, 16'h0001, 0, 0));
        tbl.push_back(v(1, S_D, 0, 16'h0,    1, 16'hBEEF, 0, 16'h0001, 16'hBEEF, 16'h0002, 1, 0));
        tbl.push_back(v(1, S_D, 0, 16'h0,    1, 16'h9999, 0, 16'h0001, 16'hBEEF, 16'h0002, 0, 0));
        // en drops while a request is in flight: it still completes
        tbl.push_back(v(1, S_F, 0, 16'h0,    0, 16'h0,    1, 16'h0002, 16'hBEEF, 16'h0002, 0, 0));
        tbl.push_back(v(0, S_D, 0, 16'h0,    1, 16'h4321, 0, 16'h0002, 16'h4321, 16'h0003, 1, 0));

        do_reset();
        expect_all("reset", 0, 16'h0000, 16'h0000, 16'h0000, 0, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].en, tbl[i].st, tbl[i].ld, tbl[i].tgt, tbl[i].ack, tbl[i].rd);
            cycle();
            expect_all($sformatf("vec%0d", i), tbl[i].req, tbl[i].addr, tbl[i].ir,
                       tbl[i].pc, tbl[i].done, tbl[i].err);
        end

        // Timeout: request held TIMEOUT cycles, then sticky error
        drive(1, S_H, 0, 16'h0, 0, 16'h0);
        cycle();
        drive(1, S_F, 0, 16'h0, 0, 16'h0);
        for (int i = 0; i < TIMEOUT; i++) begin
            cycle();
            chk($sformatf("to_req%0d", i), 32'(mem_req), 32'd1);
            chk($sformatf("to_addr%0d", i), 32'(mem_addr), 32'h0003);
            chk($sformatf("to_err%0d", i), 32'(fetch_err), 32'd0);
        end
        cycle();
        expect_all("timeout", 0, 16'h0003, 16'h4321, 16'h0003, 0, 1);
        drive(1, S_E, 1, 16'h1234, 0, 16'h0);
        cycle();
        expect_all("err_pcload", 0, 16'h0003, 16'h4321, 16'h0003, 0, 1);
        drive(1, S_H, 0, 16'h0, 0, 16'h0);
        cycle();
        drive(1, S_F, 0, 16'h0, 1, 16'hAAAA);
        cycle();
        expect_all("err_fetch", 0, 16'h0003, 16'h4321, 16'h0003, 0, 1);

        // Asynchronous reset in the middle of a request
        do_reset();
        drive(1, S_F, 0, 16'h0, 0, 16'h0);
        cycle();
        drive(1, S_F, 0, 16'h0, 1, 16'hCAFE);
        cycle();
        drive(1, S_E, 1, 16'h0100, 0, 16'h0);
        cycle();
        drive(1, S_F, 0, 16'h0, 0, 16'h0);
        cycle();
        expect_all("pre_rst", 1, 16'h0100, 16'hCAFE, 16'h0100, 0, 0);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        expect_all("async_rst", 0, 16'h0000, 16'h0000, 16'h0000, 0, 0);
        drive(1, S_F, 0, 16'h0, 1, 16'hDEAD);
        cycle();
        rst = 1'b0;
        expect_all("in_rst", 0, 16'h0000, 16'h0000, 16'h0000, 0, 0);
        drive(1, S_H, 0, 16'h0, 0, 16'h0);
        cycle();
        drive(1, S_F, 0, 16'h0, 0, 16'h0);
        cycle();
        expect_all("post_rst_req", 1, 16'h0000, 16'h0000, 16'h0000, 0, 0);
        drive(1, S_F, 0, 16'h0, 1, 16'h5A5A);
        cycle();
        expect_all("post_rst_ack", 0, 16'h0000, 16'h5A5A, 16'h0001, 1, 0);

        // Randomized traffic against the reference model
        for (int seg = 0; seg < 6; seg++) begin
            do_reset();
            for (int n = 0; n < 300; n++) begin
                drive(($urandom_range(0, 9) < 8), 2'($urandom_range(0, 3)),
                      ($urandom_range(0, 3) == 0), 16'($urandom),
                      (seg % 2 == 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 9) < 1),
                      16'($urandom));
                cycle();
                check_model($sformatf("rnd%0d_%0d", seg, n));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
